// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire stage: ALU control codes,
// MIPS R-type funct values and the issue controller state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_MULT = 4'b1000;
    localparam logic [3:0] ALU_DIV  = 4'b1001;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ISSUE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
    localparam logic [1:0] ST_WB_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ISSUE = ST_ISSUE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_WB    = ST_WB_ENC
    } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational map from MIPS funct to ALU control plus op-class flags.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       is_move,
    output logic       move_hi,
    output logic       is_muldiv,
    output logic       illegal
);

    // Decode funct; MOVE ops carry no meaningful ALU code.
    always_comb begin
        alu_control = ALU_ADD;
        is_move     = 1'b0;
        move_hi     = 1'b0;
        is_muldiv   = 1'b0;
        illegal     = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_NOR:  alu_control = ALU_NOR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_SLL:  alu_control = ALU_SLL;
            FN_SRL:  alu_control = ALU_SRL;
            FN_MULT: begin
                alu_control = ALU_MULT;
                is_muldiv   = 1'b1;
            end
            FN_DIV: begin
                alu_control = ALU_DIV;
                is_muldiv   = 1'b1;
            end
            FN_MFHI: begin
                is_move = 1'b1;
                move_hi = 1'b1;
            end
            FN_MFLO: is_move = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire stage in front of the ALU.
//   state | meaning
//   IDLE  | ready for a request; MOVE/illegal ops retire directly
//   ISSUE | alu_en pulsed for one cycle, operands held
//   WAIT  | waiting for alu_done, bounded by TIMEOUT_CYCLES
//   WB    | one-cycle writeback record presented
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_rs_val,
    input  logic [31:0] req_rt_val,
    input  logic [4:0]  req_rd,
    output logic        alu_en,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic        alu_overflow,
    input  logic        alu_done,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_ovf,
    output logic        wb_err,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    logic [3:0] dec_ctrl;
    logic       dec_move;
    logic       dec_hi;
    logic       dec_muldiv;
    logic       dec_illegal;

    alu_funct_decode u_decode (
        .funct       (req_funct),
        .alu_control (dec_ctrl),
        .is_move     (dec_move),
        .move_hi     (dec_hi),
        .is_muldiv   (dec_muldiv),
        .illegal     (dec_illegal)
    );

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        muldiv_q, muldiv_d;
    logic        alu_en_q, alu_en_d;
    logic [3:0]  alu_control_q, alu_control_d;
    logic [31:0] alu_srcA_q, alu_srcA_d;
    logic [31:0] alu_srcB_q, alu_srcB_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_ovf_q, wb_ovf_d;
    logic        wb_err_q, wb_err_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        muldiv_d      = muldiv_q;
        alu_en_d      = 1'b0;
        alu_control_d = alu_control_q;
        alu_srcA_d    = alu_srcA_q;
        alu_srcB_d    = alu_srcB_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        wb_ovf_d      = wb_ovf_q;
        wb_err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wb_rd_d = req_rd;
                    if (dec_illegal) begin
                        wb_data_d  = '0;
                        wb_ovf_d   = 1'b0;
                        wb_err_d   = 1'b1;
                        wb_valid_d = 1'b1;
                        state_d    = ST_WB;
                    end else if (dec_move) begin
                        wb_data_d  = dec_hi ? alu_hi : alu_lo;
                        wb_ovf_d   = 1'b0;
                        wb_we_d    = 1'b1;
                        wb_valid_d = 1'b1;
                        state_d    = ST_WB;
                    end else begin
                        alu_control_d = dec_ctrl;
                        alu_srcA_d    = (dec_ctrl == ALU_SLL || dec_ctrl == ALU_SRL)
                                        ? {27'd0, req_shamt} : req_rs_val;
                        alu_srcB_d    = req_rt_val;
                        muldiv_d      = dec_muldiv;
                        alu_en_d      = 1'b1;
                        state_d       = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (alu_done) begin
                    wb_data_d  = muldiv_q ? 32'd0 : alu_result;
                    wb_ovf_d   = alu_overflow;
                    wb_we_d    = ~muldiv_q;
                    wb_valid_d = 1'b1;
                    state_d    = ST_WB;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
                        wb_data_d  = '0;
                        wb_ovf_d   = 1'b0;
                        wb_err_d   = 1'b1;
                        wb_valid_d = 1'b1;
                        state_d    = ST_WB;
                    end
                end
            end
            ST_WB: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            muldiv_q      <= 1'b0;
            alu_en_q      <= 1'b0;
            alu_control_q <= '0;
            alu_srcA_q    <= '0;
            alu_srcB_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            wb_ovf_q      <= 1'b0;
            wb_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            muldiv_q      <= muldiv_d;
            alu_en_q      <= alu_en_d;
            alu_control_q <= alu_control_d;
            alu_srcA_q    <= alu_srcA_d;
            alu_srcB_q    <= alu_srcB_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            wb_ovf_q      <= wb_ovf_d;
            wb_err_q      <= wb_err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign alu_en      = alu_en_q;
    assign alu_control = alu_control_q;
    assign alu_srcA    = alu_srcA_q;
    assign alu_srcB    = alu_srcB_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_ovf      = wb_ovf_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a
// scoreboard of expected writeback records.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_rs_val;
    logic [31:0] req_rt_val;
    logic [4:0]  req_rd;
    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] alu_srcA;
    logic [31:0] alu_srcB;
    logic [31:0] m_result = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_ovf = 1'b0;
    logic        m_done = 1'b0;
    logic        withhold = 1'b0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf;
    logic        wb_err;
    logic        busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct    (req_funct),
        .req_shamt    (req_shamt),
        .req_rs_val   (req_rs_val),
        .req_rt_val   (req_rt_val),
        .req_rd       (req_rd),
        .alu_en       (alu_en),
        .alu_control  (alu_control),
        .alu_srcA     (alu_srcA),
        .alu_srcB     (alu_srcB),
        .alu_result   (m_result),
        .alu_hi       (m_hi),
        .alu_lo       (m_lo),
        .alu_overflow (m_ovf),
        .alu_done     (m_done),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_ovf       (wb_ovf),
        .wb_err       (wb_err),
        .busy         (busy)
    );

    // Behavioural ALU: one-cycle response to alu_en unless withheld.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (alu_en === 1'b1 && !withhold) begin
            m_done <= 1'b1;
            m_ovf  <= 1'b0;
            case (alu_control)
                4'b0000: {m_ovf, m_result} <= {1'b0, alu_srcA} + {1'b0, alu_srcB};
                4'b0001: {m_ovf, m_result} <= {1'b0, alu_srcA} - {1'b0, alu_srcB};
                4'b0010: m_result <= alu_srcA & alu_srcB;
                4'b0011: m_result <= alu_srcA | alu_srcB;
                4'b0100: m_result <= ~(alu_srcA | alu_srcB);
                4'b0101: m_result <= ($signed(alu_srcA) < $signed(alu_srcB)) ? 32'd1 : 32'd0;
                4'b0110: m_result <= alu_srcB << alu_srcA[4:0];
                4'b0111: m_result <= alu_srcB >> alu_srcA[4:0];
                4'b1000: begin
                    {m_hi, m_lo} <= {32'd0, alu_srcA} * {32'd0, alu_srcB};
                    m_result     <= 32'hDEAD_BEEF;
                end
                4'b1001: begin
                    m_result <= 32'hDEAD_BEEF;
                    if (alu_srcB == 32'd0) begin
                        m_ovf <= 1'b1;
                    end else begin
                        m_hi <= alu_srcA % alu_srcB;
                        m_lo <= alu_srcA / alu_srcB;
                    end
                end
                default: m_result <= 32'd0;
            endcase
        end
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        ovf;
        logic        err;
        int          lat;
        int          en_n;
        logic [3:0]  ctrl;
        logic [31:0] sa;
        logic [31:0] sb;
    } exp_t;

    exp_t sbq[$];
    int   tests  = 0;
    int   failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [4:0] sh,
                          input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                          input logic [31:0] x_data, input logic x_we, input logic x_ovf,
                          input logic x_err, input int x_lat, input int x_en,
                          input logic [3:0] x_ctrl, input logic [31:0] x_sa);
        exp_t        e;
        int          k;
        int          en_n;
        logic        found;
        logic [3:0]  ctrl_s;
        logic [31:0] sa_s;
        logic [31:0] sb_s;
        e = '{rd: rd, data: x_data, we: x_we, ovf: x_ovf, err: x_err, lat: x_lat,
              en_n: x_en, ctrl: x_ctrl, sa: x_sa, sb: rt};
        sbq.push_back(e);
        @(negedge clk);
        req_funct  = f;
        req_shamt  = sh;
        req_rs_val = rs;
        req_rt_val = rt;
        req_rd     = rd;
        req_valid  = 1'b1;
        chk({name, ".ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        found  = 1'b0;
        k      = 0;
        en_n   = 0;
        ctrl_s = '0;
        sa_s   = '0;
        sb_s   = '0;
        while (!found && k < 40) begin
            @(negedge clk);
            k++;
            if (alu_en === 1'b1) begin
                en_n++;
                ctrl_s = alu_control;
                sa_s   = alu_srcA;
                sb_s   = alu_srcB;
            end
            if (wb_valid === 1'b1) found = 1'b1;
        end
        chk({name, ".wb_seen"}, {31'd0, found}, 32'd1);
        e = sbq.pop_front();
        chk({name, ".latency"}, k, e.lat);
        chk({name, ".alu_en_cycles"}, en_n, e.en_n);
        chk({name, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
        chk({name, ".wb_data"}, wb_data, e.data);
        chk({name, ".wb_we"}, {31'd0, wb_we}, {31'd0, e.we});
        chk({name, ".wb_ovf"}, {31'd0, wb_ovf}, {31'd0, e.ovf});
        chk({name, ".wb_err"}, {31'd0, wb_err}, {31'd0, e.err});
        if (e.en_n > 0) begin
            chk({name, ".alu_control"}, {28'd0, ctrl_s}, {28'd0, e.ctrl});
            chk({name, ".alu_srcA"}, sa_s, e.sa);
            chk({name, ".alu_srcB"}, sb_s, e.sb);
        end
        @(negedge clk);
        chk({name, ".wb_pulse_end"}, {31'd0, wb_valid}, 32'd0);
        chk({name, ".idle_after"}, {30'd0, busy, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int wb_cnt;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_funct  = '0;
        req_shamt  = '0;
        req_rs_val = '0;
        req_rt_val = '0;
        req_rd     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.alu_en", {31'd0, alu_en}, 32'd0);
        chk("reset.alu_control", {28'd0, alu_control}, 32'd0);
        chk("reset.alu_srcA", alu_srcA, 32'd0);
        chk("reset.alu_srcB", alu_srcB, 32'd0);
        chk("reset.wb_flags", {27'd0, wb_valid, wb_we, wb_ovf, wb_err, 1'b0}, 32'd0);
        chk("reset.wb_rd_data", wb_data | {27'd0, wb_rd}, 32'd0);
        rst = 1'b0;

        //      name     funct  sh  rs            rt            rd    data          we    ovf   err   lat en ctrl     srcA
        run_op("add",   6'h20, 0,  32'd5,        32'd7,        5'd3, 32'd12,       1'b1, 1'b0, 1'b0, 3, 1, 4'b0000, 32'd5);
        run_op("sub",   6'h22, 0,  32'd10,       32'd3,        5'd4, 32'd7,        1'b1, 1'b0, 1'b0, 3, 1, 4'b0001, 32'd10);
        run_op("slt",   6'h2A, 0,  32'hFFFFFFFF, 32'd1,        5'd5, 32'd1,        1'b1, 1'b0, 1'b0, 3, 1, 4'b0101, 32'hFFFFFFFF);
        run_op("nor",   6'h27, 0,  32'h0F0F0000, 32'h000000F0, 5'd6, 32'hF0F0FF0F, 1'b1, 1'b0, 1'b0, 3, 1, 4'b0100, 32'h0F0F0000);
        run_op("sll",   6'h00, 4,  32'hFFFF0000, 32'd1,        5'd7, 32'h10,       1'b1, 1'b0, 1'b0, 3, 1, 4'b0110, 32'd4);
        run_op("srl",   6'h02, 31, 32'd0,        32'h80000000, 5'd8, 32'd1,        1'b1, 1'b0, 1'b0, 3, 1, 4'b0111, 32'd31);
        run_op("mult",  6'h18, 0,  32'h10000,    32'h10000,    5'd9, 32'd0,        1'b0, 1'b0, 1'b0, 3, 1, 4'b1000, 32'h10000);
        run_op("mfhi",  6'h10, 0,  32'd0,        32'd0,        5'd10, 32'd1,       1'b1, 1'b0, 1'b0, 1, 0, 4'b0000, 32'd0);
        run_op("mflo",  6'h12, 0,  32'd0,        32'd0,        5'd11, 32'd0,       1'b1, 1'b0, 1'b0, 1, 0, 4'b0000, 32'd0);
        run_op("div0",  6'h1A, 0,  32'd100,      32'd0,        5'd12, 32'd0,       1'b0, 1'b1, 1'b0, 3, 1, 4'b1001, 32'd100);
        run_op("illegal", 6'h3F, 0, 32'd1,       32'd2,        5'd13, 32'd0,       1'b0, 1'b0, 1'b1, 1, 0, 4'b0000, 32'd0);

        withhold = 1'b1;
        run_op("timeout", 6'h20, 0, 32'd1,       32'd2,        5'd14, 32'd0,       1'b0, 1'b0, 1'b1, 17, 1, 4'b0000, 32'd1);
        withhold = 1'b0;
        run_op("add2",  6'h20, 0,  32'd100,      32'd23,       5'd15, 32'd123,     1'b1, 1'b0, 1'b0, 3, 1, 4'b0000, 32'd100);

        // Reset while WAIT is stalled on a withheld done.
        withhold = 1'b1;
        @(negedge clk);
        req_funct  = 6'h22;
        req_shamt  = '0;
        req_rs_val = 32'd9;
        req_rt_val = 32'd4;
        req_rd     = 5'd7;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstwait.busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstwait.busy", {31'd0, busy}, 32'd0);
        chk("rstwait.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstwait.alu_en", {31'd0, alu_en}, 32'd0);
        chk("rstwait.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstwait.wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rstwait.wb_data", wb_data, 32'd0);
        chk("rstwait.alu_control", {28'd0, alu_control}, 32'd0);
        rst      = 1'b0;
        withhold = 1'b0;
        wb_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) wb_cnt++;
        end
        chk("rstwait.no_wb", wb_cnt, 0);

        run_op("and",   6'h24, 0,  32'hFF00FF00, 32'h0FF00FF0, 5'd16, 32'h0F000F00, 1'b1, 1'b0, 1'b0, 3, 1, 4'b0010, 32'hFF00FF00);
        chk("scoreboard.empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
